// File: rtl/chopper_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chopper_ctrl_pkg
//  Description : Shared definitions for the fixed-off-time coil chopper:
//                state encoding and the completed-OFF-phase counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package chopper_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_idle  = 3'd0;
    localparam state_t c_blank = 3'd1;
    localparam state_t c_on    = 3'd2;
    localparam state_t c_off   = 3'd3;
    localparam state_t c_fault = 3'd4;

    localparam int c_off_count_w = 16;

endpackage
`default_nettype wire

// File: rtl/chopper_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones, with synchronous clear.
//  Ports       : clk     - clock
//                i_clr   - synchronous clear (wins over increment)
//                i_inc   - increment request
//                o_count - current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/chopper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : chopper_ctrl
//  Description : Fixed-off-time current chopper for one motor coil. Sequences
//                BLANK -> ON -> OFF phases using an external down-counter
//                timer and latches a short-circuit fault when overcurrent
//                repeatedly appears right after blanking.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                enable         - chopping enabled (low forces IDLE)
//                current_over   - coil current above target
//                blank_time     - blanking duration load value
//                off_time       - OFF duration load value
//                timer          - count from the downstream timer
//                timer_start    - one-cycle load strobe to the timer
//                timer_load     - value loaded when timer_start is high
//                phase_on       - H-bridge drive active
//                decay_fast     - fast decay during OFF
//                fault          - latched short-circuit fault
//                off_count      - saturating count of completed OFF phases
//  Revision    : 1.0  initial release
// ============================================================================
module chopper_ctrl
    import chopper_ctrl_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SHORT_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     current_over,
    input  logic [WIDTH-1:0]         blank_time,
    input  logic [WIDTH-1:0]         off_time,
    input  logic [WIDTH-1:0]         timer,
    output logic                     timer_start,
    output logic [WIDTH-1:0]         timer_load,
    output logic                     phase_on,
    output logic                     decay_fast,
    output logic                     fault,
    output logic [c_off_count_w-1:0] off_count
);

    localparam logic [3:0] c_short_limit = 4'(SHORT_LIMIT);

    state_t     r_state;
    state_t     w_next;
    logic       r_first_on;
    logic [3:0] r_short;
    logic [3:0] w_short_next;
    logic [3:0] w_short_inc;
    logic       w_settle;
    logic       w_expired;
    logic       w_start;
    logic       w_off_done;

    // The load strobe is high exactly in the first BLANK/OFF cycle, which is
    // the cycle where the timer still shows its previous (stale) count.
    assign w_settle    = timer_start;
    assign w_expired   = (timer == '0) && !w_settle;
    assign w_short_inc = r_short + 4'd1;

    always_comb begin
        w_next       = r_state;
        w_short_next = r_short;
        w_off_done   = 1'b0;
        if (!enable) begin
            w_next = c_idle;
            if (r_state == c_fault) begin
                w_short_next = '0;
            end
        end else begin
            case (r_state)
                c_idle:  w_next = c_blank;
                c_blank: begin
                    if (w_expired) begin
                        w_next = c_on;
                    end
                end
                c_on: begin
                    if (current_over) begin
                        if (r_first_on) begin
                            // Overcurrent straight after blanking: likely short.
                            if (w_short_inc == c_short_limit) begin
                                w_next = c_fault;
                            end else begin
                                w_short_next = w_short_inc;
                                w_next       = c_off;
                            end
                        end else begin
                            w_short_next = '0;
                            w_next       = c_off;
                        end
                    end
                end
                c_off: begin
                    if (w_expired) begin
                        w_off_done = 1'b1;
                        w_next     = c_blank;
                    end
                end
                c_fault: w_next = c_fault;
                default: w_next = c_idle;
            endcase
        end
    end

    assign w_start = (w_next != r_state) && ((w_next == c_blank) || (w_next == c_off));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_short     <= '0;
            r_first_on  <= 1'b0;
            timer_start <= 1'b0;
            timer_load  <= '0;
            phase_on    <= 1'b0;
            decay_fast  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_short     <= w_short_next;
            r_first_on  <= (w_next == c_on) && (r_state != c_on);
            timer_start <= w_start;
            if (w_start) begin
                timer_load <= (w_next == c_blank) ? blank_time : off_time;
            end
            phase_on    <= (w_next == c_blank) || (w_next == c_on);
            decay_fast  <= (w_next == c_off);
            fault       <= (w_next == c_fault);
        end
    end

    sat_counter #(
        .WIDTH (c_off_count_w)
    ) u_off_cnt (
        .clk     (clk),
        .i_clr   (reset),
        .i_inc   (w_off_done),
        .o_count (off_count)
    );

endmodule
`default_nettype wire

// File: doc/chopper_ctrl.md
Name: chopper_ctrl

Overview:
- Fixed-off-time current chopper for one motor coil; sits directly upstream of the microstepper down-counter timer.
- Drives the timer's load strobe and load value, and consumes its count to sequence blanking, on-time and off-time phases of the H-bridge.
- Also flags a latched short-circuit fault when overcurrent persists immediately after blanking.

Parameters:
- WIDTH, 10, width of the timer load value and timer count (matches the downstream timer).
- SHORT_LIMIT, 3, number of consecutive immediate-overcurrent cycles that latch a fault (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  chopping enabled; low forces IDLE.
- current_over  input  1  comparator: coil current above target (already synchronised).
- blank_time  input  WIDTH  blanking duration load value.
- off_time  input  WIDTH  off-phase duration load value.
- timer  input  WIDTH  current count from the downstream timer.
- timer_start  output  1  one-cycle load strobe to the timer.
- timer_load  output  WIDTH  value loaded into the timer when timer_start is high.
- phase_on  output  1  H-bridge drive active.
- decay_fast  output  1  bridge in fast-decay during OFF.
- fault  output  1  latched short-circuit fault.
- off_count  output  16  saturating count of completed OFF phases.

Behaviour:
- One clock and one reset: reset is synchronous and active-high.
- Reset values:
  - state IDLE; all outputs 0; timer_load 0.
  - short counter 0; off_count 0; fault 0.
- States: IDLE, BLANK, ON, OFF, FAULT. All outputs are registered and decoded from state.
- Settle flag: high during the first cycle in BLANK or OFF. Expiry means timer == 0 with the settle flag low. This masks the stale timer value present during the load cycle.
- IDLE:
  - phase_on = 0, decay_fast = 0.
  - enable = 1 moves to BLANK at the next edge.
- BLANK:
  - On entry, timer_start = 1 for exactly the first cycle and timer_load = blank_time.
  - phase_on = 1; current_over is ignored.
  - On expiry, moves to ON.
  - The BLANK phase lasts blank_time + 2 cycles; blank_time = 0 gives 2 cycles.
- ON:
  - phase_on = 1.
  - If current_over = 1 in the first ON cycle, increment the short counter and go to OFF. If the counter would reach SHORT_LIMIT, go to FAULT instead.
  - If current_over = 1 in any later ON cycle, clear the short counter and go to OFF.
  - Otherwise stay in ON; there is no maximum on-time.
- OFF:
  - On entry, timer_start = 1 for the first cycle and timer_load = off_time.
  - phase_on = 0, decay_fast = 1.
  - On expiry, increment off_count (saturating at 0xFFFF) and go to BLANK. The OFF phase lasts off_time + 2 cycles.
- FAULT:
  - phase_on = 0, decay_fast = 0, fault = 1.
  - Held until enable = 0; then moves to IDLE and clears fault and the short counter.
- enable = 0 in any non-FAULT state:
  - Moves to IDLE at the next edge; outputs go to 0 that same edge.
  - Any pending timer count is abandoned; off_count is kept.
- Simultaneous events:
  - enable low takes priority over every other transition.
  - In ON, current_over takes priority over everything except enable.
- blank_time and off_time are sampled only on the timer_start cycle; changes mid-phase take effect at the next phase.
- timer_load keeps its last value when timer_start = 0.
- Reset mid-operation returns to the reset values on the next edge. The timer is reset by the same reset.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, BLANK=1, ON=2, OFF=3, FAULT=4, 3 bits);
  - the off_count width constant (16).
- One natural sub-module: sat_counter (parameterised width, increment, synchronous clear, saturating), used for off_count.
- The short counter is small enough to stay inline.

Test Plan:
- Reset, then enable=1 with blank_time=4, off_time=6, current_over=0 → timer_start pulses once with timer_load=4; BLANK lasts 6 cycles; then ON with phase_on held high.
- In ON, assert current_over for 1 cycle at ON cycle 5 → timer_start with timer_load=6; OFF lasts 8 cycles with decay_fast=1; BLANK is re-entered; off_count = 1.
- SHORT_LIMIT=3, current_over held at 1 → 2 OFF phases, then FAULT on the third immediate overcurrent; fault=1 and phase_on=0 until enable drops; fault clears the cycle after.
- blank_time=0, off_time=0 → BLANK and OFF each last exactly 2 cycles; no stuck state.
- enable dropped mid-OFF with timer=3 → IDLE next edge, all outputs 0; re-enable starts from BLANK with a fresh timer_start.
- Force off_count to 0xFFFE, run 3 OFF phases → saturates at 0xFFFF. Assert reset mid-BLANK → every output and the state return to 0 on the next edge.
